// File: rtl/iir_pkg.sv
// rtl/iir_pkg.sv - shared types, tap indexing and arithmetic helpers for the IIR stream filter
package iir_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_MAC,
        S_WRITE,
        S_DONE
    } state_t;

    // Coefficient bank layout: b0..bN first, then a1..aN
    localparam int B_BASE = 0;

    function automatic int a_base(input int order);
        return order + 1;
    endfunction

    function automatic int ntaps(input int order);
        return 2 * order + 1;
    endfunction

    // Wide enough that a full sum of NTAPS worst-case products cannot overflow
    function automatic int acc_width(input int data_w, input int coef_w, input int order);
        return data_w + coef_w + $clog2(2 * order + 1);
    endfunction

    // Round half toward +inf, drop the fractional bits, clamp to a data_w signed range
    function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                      input int frac,
                                                      input int data_w,
                                                      output logic sat);
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r   = (acc + (64'sd1 <<< (frac - 1))) >>> frac;
        hi  = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo  = -(64'sd1 <<< (data_w - 1));
        sat = 1'b0;
        if (r > hi) begin
            r   = hi;
            sat = 1'b1;
        end else if (r < lo) begin
            r   = lo;
            sat = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/iir_mac.sv
// rtl/iir_mac.sv - shared multiply-accumulate with round/saturate of the next accumulator value
module iir_mac
    import iir_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 20,
    parameter int COEF_FRAC = 16,
    parameter int ACC_W     = 40
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     en,
    input  logic                     sub,
    input  logic signed [COEF_W-1:0] coef,
    input  logic signed [DATA_W-1:0] data,
    output logic signed [DATA_W-1:0] y_next,
    output logic                     sat_next
);

    localparam int P_W = DATA_W + COEF_W;

    logic signed [P_W-1:0]   prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [63:0]      y_wide;
    logic                    unused_hi;

    // Next accumulator value; the result is taken from it so the last tap lands in the same cycle
    always_comb begin
        prod     = P_W'(coef) * P_W'(data);
        prod_ext = ACC_W'(prod);
        acc_next = acc;
        if (clr) begin
            acc_next = '0;
        end else if (en) begin
            acc_next = sub ? (acc - prod_ext) : (acc + prod_ext);
        end
        y_wide = round_sat(64'(acc_next), COEF_FRAC, DATA_W, sat_next);
        y_next = y_wide[DATA_W-1:0];
    end

    assign unused_hi = ^y_wide[63:DATA_W];

    // Accumulator register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/iir_stream.sv
// rtl/iir_stream.sv - direct-form-I IIR filter streaming from sample memory to result memory
module iir_stream
    import iir_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 20,
    parameter int COEF_FRAC = 16,
    parameter int ORDER     = 5,
    parameter int ADDR_W    = 20
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [ADDR_W-1:0]                 num_samples,
    input  logic                              coef_we,
    input  logic [$clog2(2*ORDER+1)-1:0]      coef_addr,
    input  logic signed [COEF_W-1:0]          coef_wdata,
    output logic                              busy,
    output logic                              load,
    output logic [ADDR_W-1:0]                 RAddr,
    input  logic signed [DATA_W-1:0]          DIn,
    output logic                              WEN,
    output logic [ADDR_W-1:0]                 WAddr,
    output logic signed [DATA_W-1:0]          Yn,
    output logic                              Finish,
    output logic                              sat_flag
);

    localparam int NTAPS  = ntaps(ORDER);
    localparam int A_BASE = a_base(ORDER);
    localparam int CA_W   = $clog2(NTAPS);
    localparam int ACC_W  = acc_width(DATA_W, COEF_W, ORDER);

    state_t                   state;
    logic [ADDR_W-1:0]        n;
    logic [ADDR_W-1:0]        ns;
    logic [CA_W-1:0]          i;
    logic signed [COEF_W-1:0] coef   [NTAPS];
    logic signed [DATA_W-1:0] x_hist [ORDER+1];
    logic signed [DATA_W-1:0] y_hist [ORDER];

    logic                     idle_like;
    logic signed [COEF_W-1:0] mac_coef;
    logic signed [DATA_W-1:0] mac_data;
    logic                     mac_sub;
    logic signed [DATA_W-1:0] mac_y;
    logic                     mac_sat;

    assign idle_like = (state == S_IDLE) || (state == S_DONE);

    // Tap operand select: x[n-i] for feed-forward taps, y[n-(i-ORDER)] for feedback taps
    always_comb begin
        mac_coef = '0;
        mac_data = '0;
        mac_sub  = (i >= CA_W'(A_BASE));
        for (int k = 0; k < NTAPS; k++) begin
            if (i == CA_W'(k)) mac_coef = coef[k];
        end
        for (int k = 0; k <= ORDER; k++) begin
            if (i == CA_W'(B_BASE + k)) mac_data = x_hist[k];
        end
        for (int k = 0; k < ORDER; k++) begin
            if (i == CA_W'(A_BASE + k)) mac_data = y_hist[k];
        end
    end

    iir_mac #(
        .DATA_W   (DATA_W),
        .COEF_W   (COEF_W),
        .COEF_FRAC(COEF_FRAC),
        .ACC_W    (ACC_W)
    ) u_mac (
        .clk     (clk),
        .rst     (rst),
        .clr     (state == S_CAPTURE),
        .en      (state == S_MAC),
        .sub     (mac_sub),
        .coef    (mac_coef),
        .data    (mac_data),
        .y_next  (mac_y),
        .sat_next(mac_sat)
    );

    // Control FSM, coefficient bank and history registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            load     <= 1'b0;
            WEN      <= 1'b0;
            Finish   <= 1'b0;
            sat_flag <= 1'b0;
            RAddr    <= '0;
            WAddr    <= '0;
            Yn       <= '0;
            n        <= '0;
            ns       <= '0;
            i        <= '0;
            for (int k = 0; k < NTAPS; k++) coef[k] <= '0;
            for (int k = 0; k <= ORDER; k++) x_hist[k] <= '0;
            for (int k = 0; k < ORDER; k++) y_hist[k] <= '0;
        end else begin
            if (coef_we && idle_like) begin
                for (int k = 0; k < NTAPS; k++) begin
                    if (coef_addr == CA_W'(k)) coef[k] <= coef_wdata;
                end
            end
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        ns       <= num_samples;
                        n        <= '0;
                        sat_flag <= 1'b0;
                        for (int k = 0; k <= ORDER; k++) x_hist[k] <= '0;
                        for (int k = 0; k < ORDER; k++) y_hist[k] <= '0;
                        if (num_samples == '0) begin
                            state  <= S_DONE;
                            Finish <= 1'b1;
                            busy   <= 1'b0;
                        end else begin
                            state  <= S_FETCH;
                            Finish <= 1'b0;
                            busy   <= 1'b1;
                            load   <= 1'b1;
                            RAddr  <= '0;
                        end
                    end
                end
                S_FETCH: begin
                    load  <= 1'b0;
                    state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    x_hist[0] <= DIn;
                    for (int k = 1; k <= ORDER; k++) x_hist[k] <= x_hist[k-1];
                    i     <= '0;
                    state <= S_MAC;
                end
                S_MAC: begin
                    if (i == CA_W'(NTAPS - 1)) begin
                        state     <= S_WRITE;
                        WEN       <= 1'b1;
                        WAddr     <= n;
                        Yn        <= mac_y;
                        y_hist[0] <= mac_y;
                        for (int k = 1; k < ORDER; k++) y_hist[k] <= y_hist[k-1];
                        if (mac_sat) sat_flag <= 1'b1;
                    end else begin
                        i <= i + 1'b1;
                    end
                end
                S_WRITE: begin
                    WEN <= 1'b0;
                    if (n == ns - 1'b1) begin
                        state  <= S_DONE;
                        Finish <= 1'b1;
                        busy   <= 1'b0;
                    end else begin
                        n     <= n + 1'b1;
                        RAddr <= n + 1'b1;
                        load  <= 1'b1;
                        state <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iir_stream.sv
// tb/tb_iir_stream.sv - self-checking bench for iir_stream
module tb_iir_stream;

    localparam int DATA_W    = 16;
    localparam int COEF_W    = 20;
    localparam int COEF_FRAC = 16;
    localparam int ORDER     = 5;
    localparam int ADDR_W    = 20;
    localparam int NT        = 2 * ORDER + 1;
    localparam int CA_W      = $clog2(NT);
    localparam int PERIOD    = 2 * ORDER + 4;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     start;
    logic [ADDR_W-1:0]        num_samples;
    logic                     coef_we;
    logic [CA_W-1:0]          coef_addr;
    logic signed [COEF_W-1:0] coef_wdata;
    logic                     busy;
    logic                     load;
    logic [ADDR_W-1:0]        RAddr;
    logic signed [DATA_W-1:0] DIn;
    logic                     WEN;
    logic [ADDR_W-1:0]        WAddr;
    logic signed [DATA_W-1:0] Yn;
    logic                     Finish;
    logic                     sat_flag;

    iir_stream #(
        .DATA_W(DATA_W), .COEF_W(COEF_W), .COEF_FRAC(COEF_FRAC), .ORDER(ORDER), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .busy(busy), .load(load), .RAddr(RAddr), .DIn(DIn),
        .WEN(WEN), .WAddr(WAddr), .Yn(Yn), .Finish(Finish), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0]        addr;
        logic signed [DATA_W-1:0] y;
    } exp_t;

    typedef struct {
        int b0;
        int a1;
        int n;
        int x[4];
        int y[4];
        bit sat;
    } vec_t;

    exp_t   sbq[$];
    int     smem[16];
    int     cb[NT];
    longint cyc = 0;
    longint prev_wen = 0;
    bit     have_prev = 1'b0;
    int     wen_count = 0;
    int     load_count = 0;
    int     n_checks = 0;
    int     n_fail = 0;
    vec_t   tbl[4];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Sample memory model and result scoreboard, both acting away from the active edge
    always @(negedge clk) begin
        exp_t e;
        if (load) begin
            DIn = DATA_W'(smem[RAddr[3:0]]);
            load_count++;
        end
        if (WEN) begin
            wen_count++;
            if (sbq.size() == 0) begin
                check("unexpected_wen", 1, 0);
            end else begin
                e = sbq.pop_front();
                check("yn", Yn, e.y);
                check("waddr", WAddr, e.addr);
            end
            if (have_prev) check("wen_spacing", cyc - prev_wen, PERIOD);
            prev_wen  = cyc;
            have_prev = 1'b1;
        end
    end

    task automatic write_coef(input int a, input int v);
        @(negedge clk);
        coef_we    = 1'b1;
        coef_addr  = CA_W'(a);
        coef_wdata = COEF_W'(v);
        @(negedge clk);
        coef_we = 1'b0;
        cb[a]   = v;
    endtask

    task automatic program_coefs(input int b0, input int a1);
        for (int a = 0; a < NT; a++) write_coef(a, (a == 0) ? b0 : ((a == ORDER + 1) ? a1 : 0));
    endtask

    // Reference: y[n] = sum b_k x[n-k] - sum a_k y[n-k], rounded half-up, clamped
    task automatic push_model(input int n);
        longint yh[16];
        longint acc;
        longint r;
        exp_t   t;
        for (int s = 0; s < n; s++) begin
            acc = 0;
            for (int k = 0; k <= ORDER; k++)
                if (s - k >= 0) acc += longint'(cb[k]) * longint'(smem[s-k]);
            for (int k = 1; k <= ORDER; k++)
                if (s - k >= 0) acc -= longint'(cb[ORDER+k]) * yh[s-k];
            r = (acc + (longint'(1) <<< (COEF_FRAC - 1))) >>> COEF_FRAC;
            if (r > 32767) r = 32767;
            else if (r < -32768) r = -32768;
            yh[s]  = r;
            t.addr = ADDR_W'(s);
            t.y    = DATA_W'(r);
            sbq.push_back(t);
        end
    endtask

    task automatic start_run(input int n);
        @(negedge clk);
        num_samples = ADDR_W'(n);
        start       = 1'b1;
        have_prev   = 1'b0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_finish(input int budget);
        int c = 0;
        while (!Finish && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("finish_reached", Finish, 1);
        check("scoreboard_drained", sbq.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int wc;
        tbl[0] = '{65536, 0, 3, '{100, -200, 32767, 0}, '{100, -200, 32767, 0}, 1'b0};
        tbl[1] = '{65536, -32768, 4, '{1000, 0, 0, 0}, '{1000, 500, 250, 125}, 1'b0};
        tbl[2] = '{131072, 0, 2, '{20000, -20000, 0, 0}, '{32767, -32768, 0, 0}, 1'b1};
        tbl[3] = '{32768, 0, 3, '{3, -3, 1, 0}, '{2, -1, 1, 0}, 1'b0};
        for (int k = 0; k < 16; k++) smem[k] = 0;
        for (int k = 0; k < NT; k++) cb[k] = 0;

        rst = 1'b1; start = 1'b0; num_samples = '0; coef_we = 1'b0;
        coef_addr = '0; coef_wdata = '0; DIn = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_load", load, 0);
        check("rst_wen", WEN, 0);
        check("rst_finish", Finish, 0);
        check("rst_sat", sat_flag, 0);
        check("rst_raddr", RAddr, 0);
        check("rst_waddr", WAddr, 0);
        check("rst_yn", Yn, 0);
        rst = 1'b0;
        @(negedge clk);

        // num_samples == 0: Finish one cycle after start, no reads
        load_count = 0;
        start_run(0);
        check("zero_finish", Finish, 1);
        check("zero_busy", busy, 0);
        repeat (5) @(negedge clk);
        check("zero_load", load_count, 0);

        // Table-driven runs
        for (int v = 0; v < 4; v++) begin
            exp_t t;
            program_coefs(tbl[v].b0, tbl[v].a1);
            for (int s = 0; s < 4; s++) smem[s] = tbl[v].x[s];
            for (int s = 0; s < tbl[v].n; s++) begin
                t.addr = ADDR_W'(s);
                t.y    = DATA_W'(tbl[v].y[s]);
                sbq.push_back(t);
            end
            start_run(tbl[v].n);
            check("sat_cleared_on_start", sat_flag, 0);
            check("busy_after_start", busy, 1);
            check("finish_low_after_start", Finish, 0);
            wait_finish(tbl[v].n * PERIOD + 40);
            check("sat_flag", sat_flag, tbl[v].sat);
            check("busy_done", busy, 0);
        end

        // start and coef_we while busy are ignored
        program_coefs(65536, 0);
        smem[0] = 100; smem[1] = -200; smem[2] = 32767;
        push_model(3);
        wc = wen_count;
        start_run(3);
        repeat (20) @(negedge clk);
        num_samples = ADDR_W'(1); start = 1'b1;
        coef_we = 1'b1; coef_addr = '0; coef_wdata = '0;
        @(negedge clk);
        start = 1'b0; coef_we = 1'b0;
        wait_finish(3 * PERIOD + 40);
        check("busy_ignore_wen_count", wen_count - wc, 3);

        // coef_we together with start: run uses the new coefficient
        @(negedge clk);
        num_samples = ADDR_W'(3); start = 1'b1; have_prev = 1'b0;
        coef_we = 1'b1; coef_addr = '0; coef_wdata = COEF_W'(32768);
        cb[0] = 32768;
        push_model(3);
        @(negedge clk);
        start = 1'b0; coef_we = 1'b0;
        wait_finish(3 * PERIOD + 40);

        // Random taps across the whole bank, checked against the reference
        for (int k = 0; k < NT; k++) begin
            if (k <= ORDER) write_coef(k, int'($urandom_range(40000)) - 20000);
            else write_coef(k, int'($urandom_range(6000)) - 3000);
        end
        for (int s = 0; s < 8; s++) smem[s] = int'($urandom_range(20000)) - 10000;
        push_model(8);
        start_run(8);
        wait_finish(8 * PERIOD + 40);

        // Reset during the MAC phase of sample 1
        program_coefs(65536, -32768);
        smem[0] = 1000; smem[1] = 0; smem[2] = 0; smem[3] = 0;
        push_model(1);
        wc = wen_count;
        start_run(4);
        begin
            int c = 0;
            while (wen_count == wc && c < 100) begin
                @(negedge clk);
                c++;
            end
        end
        check("first_wen_before_rst", wen_count - wc, 1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_load", load, 0);
        check("midrst_wen", WEN, 0);
        check("midrst_finish", Finish, 0);
        check("midrst_yn", Yn, 0);
        check("midrst_raddr", RAddr, 0);
        check("midrst_waddr", WAddr, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < NT; k++) cb[k] = 0;
        wc = wen_count;
        repeat (40) @(negedge clk);
        check("no_wen_after_rst", wen_count - wc, 0);
        check("idle_after_rst", busy, 0);
        program_coefs(65536, -32768);
        push_model(4);
        start_run(4);
        wait_finish(4 * PERIOD + 40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/iir_stream.md
Name: iir_stream

Overview:
- Parametrised, coefficient-programmable direct-form-I IIR filter that streams samples from a sample memory and writes results to a result memory.
- A single time-multiplexed multiplier-accumulator is shared across all taps.
- Filter order, data width, coefficient width/format and address width are parameters.
- Adds start/busy control, a programmable sample count, round-half-up, output saturation and a sticky saturation flag.

Parameters:
- DATA_W, 16, sample/result width, signed two's complement
- COEF_W, 20, coefficient width, signed
- COEF_FRAC, 16, fractional bits of coefficients (default Q4.16, range [-8,8))
- ORDER, 5, filter order N (N+1 feed-forward taps, N feedback taps)
- ADDR_W, 20, memory address width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; begins a run when idle
- num_samples  in  ADDR_W  samples to process; sampled on accepted start
- coef_we  in  1  coefficient write strobe
- coef_addr  in  clog2(2*ORDER+1)  0..ORDER = b0..bN; ORDER+1..2*ORDER = a1..aN
- coef_wdata  in  COEF_W  signed coefficient
- busy  out  1  high from accepted start until DONE is entered
- load  out  1  sample read enable
- RAddr  out  ADDR_W  sample read address
- DIn  in  DATA_W  signed sample, valid the cycle after load
- WEN  out  1  result write enable, one-cycle pulse per sample
- WAddr  out  ADDR_W  result write address
- Yn  out  DATA_W  signed result, valid while WEN=1
- Finish  out  1  run complete; held until next accepted start
- sat_flag  out  1  sticky; set when any output saturated; cleared on accepted start

Behaviour:
- Equation: y[n] = sum_{k=0..N} b_k*x[n-k] - sum_{k=1..N} a_k*y[n-k].
  - a_k is stored with that sign, so the feedback term is subtracted.
  - x[n<0] = y[n<0] = 0.
- Reset values: busy, load, WEN, Finish and sat_flag are 0; RAddr, WAddr and Yn are 0.
  - The coefficient bank, x/y history and accumulator are also cleared on reset.
  - State = IDLE.
- FSM states: IDLE, FETCH, CAPTURE, MAC, WRITE, DONE.
  - IDLE/DONE + start: latch num_samples, clear history and sat_flag, Finish<=0, n<=0.
    - If num_samples==0: go to DONE next cycle with Finish=1 and no reads.
    - Otherwise go to FETCH.
  - FETCH (1 cycle): load=1, RAddr=n.
  - CAPTURE (1 cycle): shift DIn into x history (x[0]=DIn), acc<=0, tap index i<=0.
  - MAC (2*ORDER+1 cycles): per cycle, acc += coef[i]*hist[i], where hist[i] is x[i] for i<=ORDER and y[i-ORDER] otherwise.
    - Terms for i>ORDER are subtracted.
  - WRITE (1 cycle): WEN=1, WAddr=n, Yn=sat(round(acc)).
    - Shift Yn into y history.
    - If n==num_samples-1, go to DONE; else n<=n+1 and go to FETCH.
  - DONE: Finish=1, busy=0; waits for start.
- Throughput: 2*ORDER+4 cycles per sample (14 at default).
  - WEN pulses are exactly that many cycles apart.
  - load is high only in FETCH.
- Arithmetic:
  - Product width DATA_W+COEF_W.
  - Accumulator ACC_W = DATA_W+COEF_W+clog2(2*ORDER+1); it never overflows.
  - Rounding: add 2^(COEF_FRAC-1), then arithmetic shift right by COEF_FRAC (round half toward +inf).
  - Saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; set sat_flag on clamp.
  - y history holds the saturated value.
- Boundaries:
  - start while busy: ignored.
  - coef_we while busy: ignored.
  - coef_we in IDLE/DONE: written next edge.
  - coef_we and start in the same cycle: coefficient is written, and the run uses the new value.
  - num_samples = 2^ADDR_W-1: address counter must not wrap before DONE.
  - rst mid-run: immediate return to IDLE, outputs take their reset values, no further WEN.

Decomposition:
- Package iir_pkg:
  - state enum
  - coefficient-index constants (B_BASE=0, A_BASE=ORDER+1, NTAPS=2*ORDER+1)
  - ACC_W derivation function
  - round/saturate function
- Sub-module iir_mac:
  - signed multiply, add/subtract, accumulate with clear and enable
  - round/saturate output and sat strobe
- FSM, history shift registers and coefficient bank stay in iir_stream.

Test Plan:
- Passthrough: b0=65536, all others 0; samples 100,-200,32767 → Yn 100,-200,32767; WAddr 0,1,2; WEN spaced 14 cycles; sat_flag=0.
- Feedback: b0=65536, a1=-32768 (y=x+0.5y[n-1]); samples 1000,0,0,0 → Yn 1000,500,250,125.
- Saturation: b0=131072 (2.0); samples 20000,-20000 → Yn 32767,-32768; sat_flag=1, cleared by next start.
- Rounding: b0=32768 (0.5); samples 3,-3,1 → Yn 2,-1,1.
- Control: num_samples=0 → Finish=1 one cycle after start, load never high. start while busy and coef_we while busy → no effect on run output.
- Reset mid-run: assert rst during MAC of sample 1 → outputs 0, state IDLE; reprogram coefficients, rerun → results identical to a fresh run.
